transpose_buffer_ctrl: RTL and testbench

TRANSPOSE_BUFFER_CTRL -- requirements
Module: transpose_buffer_ctrl

---
 rtl/tbuf_pkg.sv | 5 +
 rtl/tbuf_beat_counter.sv | 27 ++
 rtl/transpose_buffer_ctrl.sv | 100 ++++++++++
 tb/tb_transpose_buffer_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tbuf_pkg.sv
// tbuf_pkg: shared state encoding and default dimension for the transpose buffer controller
package tbuf_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;
    localparam int TBUF_N_DEFAULT = 8;
endpackage

// File: rtl/tbuf_beat_counter.sv
// tbuf_beat_counter: mod-N beat counter with wrap flag
module tbuf_beat_counter
    import tbuf_pkg::*;
#(
    parameter int N = TBUF_N_DEFAULT,
    localparam int CNT_W = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign at_max = cnt_q == CNT_W'(N - 1);
    assign cnt    = cnt_q;

    // clear wins over increment; increment wraps to zero at N-1
    always_comb cnt_d = clr ? '0 : inc ? (at_max ? '0 : cnt_q + 1'b1) : cnt_q;

    // counter register, asynchronously cleared
    always_ff @(posedge clock or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
endmodule

// File: rtl/transpose_buffer_ctrl.sv
// transpose_buffer_ctrl: load/stream/drain control of an N x N transpose buffer (optional err logic via TBUF_CTRL_ERR_EN)
module transpose_buffer_ctrl
    import tbuf_pkg::*;
#(
    parameter int N = TBUF_N_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    input  logic in_last,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    output logic out_last,
    output logic enable,
    output logic direction,
    output logic err
);
    localparam int CNT_W = $clog2(N);

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt;
    logic             at_max, inc, wrap, enable_c;

    tbuf_beat_counter #(.N(N)) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .inc    (inc),
        .clr    (1'b0),
        .cnt    (cnt),
        .at_max (at_max)
    );

    // next state, handshakes and cell control; a block boundary flips the shift direction
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        enable_c  = 1'b0;
        inc       = 1'b0;
        wrap      = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                enable_c = in_valid;
                inc      = in_valid;
                wrap     = in_valid && at_max;
                if (in_valid) state_d = at_max ? (in_last ? DRAIN : STREAM) : LOAD;
            end
            STREAM: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                inc       = in_valid && out_ready;
                enable_c  = inc;
                wrap      = inc && at_max;
                if (wrap) state_d = in_last ? DRAIN : STREAM;
            end
            DRAIN: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
                inc       = out_ready;
                enable_c  = out_ready;
                wrap      = out_ready && at_max;
                if (wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        dir_d = wrap ? ~dir_q : dir_q;
    end

    assign enable    = enable_c && !reset;
    assign direction = dir_q;
    assign out_last  = (state_q == DRAIN) && (cnt == CNT_W'(N - 1));

    // state and direction registers
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end

`ifdef TBUF_CTRL_ERR_EN
    logic err_q, err_d;

    // sticky: early in_last on an accepted row, or a row offered while draining
    always_comb err_d = err_q || (in_valid && in_ready && in_last && !at_max) || (state_q == DRAIN && in_valid);

    // error flag register, cleared only by reset
    always_ff @(posedge clock or posedge reset)
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_transpose_buffer_ctrl.sv
// tb_transpose_buffer_ctrl: vector table, directed sequences and random traffic against a block-level model
module tb_transpose_buffer_ctrl;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_last, enable, direction, err;

    int errors = 0;
    int checks = 0;

    // model: rows of the block being loaded, columns of the block being drained,
    // whether a full block sits in the buffer, whether no more input is coming,
    // and the number of block boundaries seen (direction = parity)
    int rows, cols, tog;
    bit full, drain, merr;
    int col_count, last_count;

    typedef struct packed {
        logic iv, il, ordy, ir, ov, en, ol, dir;
    } vec_t;
    vec_t tbl[$];

    transpose_buffer_ctrl #(.N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .enable    (enable),
        .direction (direction),
        .err       (err)
    );

    always #5 clock = ~clock;

    function void mreset();
        rows = 0; cols = 0; tog = 0; full = 0; drain = 0; merr = 0;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_reset();
        in_valid = 0; in_last = 0; out_ready = 0;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        mreset();
    endtask

    // one cycle against the model: drive, check at negedge, advance model at posedge
    task automatic cyc(input logic iv, input logic il, input logic ordy);
        logic e_ir, e_en, e_ol;
        bit acc, take;
        in_valid = iv; in_last = il; out_ready = ordy;
        @(negedge clock);
        e_ir = drain ? 1'b0 : full ? ordy : 1'b1;
        e_en = drain ? ordy : full ? (iv && ordy) : iv;
        e_ol = drain && cols == N - 1;
        chk("in_ready", in_ready, e_ir);
        chk("out_valid", out_valid, full);
        chk("enable", enable, e_en);
        chk("out_last", out_last, e_ol);
        chk("direction", direction, tog[0]);
        chk("err", err, merr);
        if (out_valid && ordy) col_count++;
        if (out_last) last_count++;
        acc  = iv && e_ir;
        take = drain && ordy;
`ifdef TBUF_CTRL_ERR_EN
        if ((acc && il && rows != N - 1) || (drain && iv)) merr = 1;
`endif
        @(posedge clock); #1;
        if (take) begin
            cols++;
            if (cols == N) begin cols = 0; full = 0; drain = 0; tog++; end
        end else if (acc) begin
            rows++;
            if (rows == N) begin rows = 0; cols = 0; tog++; full = 1; drain = il; end
        end
    endtask

    initial begin
        // iv il or | ir ov en ol dir
        tbl.push_back('{1,0,0, 1,0,1,0,0});
        tbl.push_back('{1,0,0, 1,0,1,0,0});
        tbl.push_back('{1,0,0, 1,0,1,0,0});
        tbl.push_back('{1,1,0, 1,0,1,0,0});
        tbl.push_back('{0,0,1, 0,1,1,0,1});
        tbl.push_back('{0,0,1, 0,1,1,0,1});
        tbl.push_back('{0,0,1, 0,1,1,0,1});
        tbl.push_back('{0,0,1, 0,1,1,1,1});
        tbl.push_back('{0,0,0, 1,0,0,0,0});
        for (int i = 0; i < 4; i++) tbl.push_back('{1,0,0, 1,0,1,0,0});
        for (int i = 0; i < 5; i++) tbl.push_back('{1,0,0, 0,1,0,0,1});
        tbl.push_back('{1,0,1, 1,1,1,0,1});
        tbl.push_back('{0,0,1, 1,1,0,0,1});
        tbl.push_back('{1,0,1, 1,1,1,0,1});

        // reset state
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_enable", enable, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_direction", direction, 1'b0);
        chk("rst_err", err, 1'b0);

        // vector table: single block, then stall and hold in STREAM
        apply_reset();
        foreach (tbl[i]) begin
            in_valid = tbl[i].iv; in_last = tbl[i].il; out_ready = tbl[i].ordy;
            @(negedge clock);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ir);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_enable", i), enable, tbl[i].en);
            chk($sformatf("tbl%0d_out_last", i), out_last, tbl[i].ol);
            chk($sformatf("tbl%0d_direction", i), direction, tbl[i].dir);
            @(posedge clock); #1;
        end

        // three back-to-back blocks, no bubble
        apply_reset();
        col_count = 0; last_count = 0;
        for (int i = 0; i < 3 * N; i++) cyc(1, i == 3 * N - 1, 1);
        for (int i = 0; i < N; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk_int("b2b_columns", col_count, 3 * N);
        chk_int("b2b_out_last", last_count, 1);

        // asynchronous reset in STREAM at cnt=2
        apply_reset();
        for (int i = 0; i < N; i++) cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        in_valid = 1; out_ready = 1;
        #2 reset = 1;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_direction", direction, 1'b0);
        chk("async_in_ready", in_ready, 1'b1);
        chk("async_enable", enable, 1'b0);
        chk("async_out_last", out_last, 1'b0);
        @(posedge clock); #1;
        in_valid = 0; out_ready = 0;
        reset = 0;
        mreset();
        col_count = 0; last_count = 0;
        for (int i = 0; i < N; i++) cyc(1, i == N - 1, 0);
        for (int i = 0; i < N; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk_int("fresh_columns", col_count, N);
        chk_int("fresh_out_last", last_count, 1);

        // early in_last on row 2: block still loads four rows
        apply_reset();
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        for (int i = 0; i < N; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        // random traffic
        apply_reset();
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(3) != 0, $urandom_range(4) == 0, $urandom_range(2) != 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
